// File: rtl/img_arb_pkg.sv
// Shared types and defaults for the image RAM port-2 arbiter.
// Holds the owner/round-robin encodings and the hold-counter helper.
package img_arb_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    localparam logic [7:0] CNT_SAT = 8'd255;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;

    typedef enum logic {
        RR_A = 1'b0,
        RR_B = 1'b1
    } rr_e;

    // Hold counter stops at 255 so a lone requester never wraps back under HOLD_MAX.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == CNT_SAT) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/img_arb_pick.sv
// Combinational grant selection from the registered ownership state.
// Produces at most one grant per cycle; never idles while someone requests.
module img_arb_pick
    import img_arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  owner_e     owner,
    input  logic [7:0] cnt,
    input  rr_e        rr,
    input  logic       req_a,
    input  logic       req_b,
    output logic       grant_a,
    output logic       grant_b
);

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (owner)
            OWN_A: begin
                if (req_a && ((cnt < HOLD_LIM) || !req_b)) begin
                    grant_a = 1'b1;
                end else if (req_b) begin
                    grant_b = 1'b1;
                end
            end
            OWN_B: begin
                if (req_b && ((cnt < HOLD_LIM) || !req_a)) begin
                    grant_b = 1'b1;
                end else if (req_a) begin
                    grant_a = 1'b1;
                end
            end
            default: begin
                // Idle port: a lone requester wins outright, a tie goes to rr.
                if (req_a && req_b) begin
                    grant_a = (rr == RR_A);
                    grant_b = (rr == RR_B);
                end else begin
                    grant_a = req_a;
                    grant_b = req_b;
                end
            end
        endcase
    end

endmodule

// File: rtl/img_port_arbiter.sv
// Two-master Avalon-MM arbiter for port 2 of the image RAM (A = frame writer,
// B = processing reader) with bounded hold, round-robin ties and read-valid return.
module img_port_arbiter
    import img_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int HOLD_MAX = 16
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   a_address,
    input  logic                a_read,
    input  logic                a_write,
    input  logic [DATA_W-1:0]   a_writedata,
    input  logic [DATA_W/8-1:0] a_byteenable,
    output logic                a_waitrequest,
    output logic [DATA_W-1:0]   a_readdata,
    output logic                a_readdatavalid,

    input  logic [ADDR_W-1:0]   b_address,
    input  logic                b_read,
    input  logic                b_write,
    input  logic [DATA_W-1:0]   b_writedata,
    input  logic [DATA_W/8-1:0] b_byteenable,
    output logic                b_waitrequest,
    output logic [DATA_W-1:0]   b_readdata,
    output logic                b_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,

    output logic                err_rw
);

    owner_e     owner_q, owner_d;
    logic [7:0] cnt_q, cnt_d;
    rr_e        rr_q, rr_d;
    logic       a_rvalid_q, a_rvalid_d;
    logic       b_rvalid_q, b_rvalid_d;
    logic       err_q, err_d;

    logic req_a, req_b;
    logic pick_a, pick_b;
    logic grant_a, grant_b;

    assign req_a = a_read | a_write;
    assign req_b = b_read | b_write;

    img_arb_pick #(
        .HOLD_MAX (HOLD_MAX)
    ) u_pick (
        .owner   (owner_q),
        .cnt     (cnt_q),
        .rr      (rr_q),
        .req_a   (req_a),
        .req_b   (req_b),
        .grant_a (pick_a),
        .grant_b (pick_b)
    );

    // Grants are suppressed while reset is held so the RAM sees no access.
    assign grant_a = pick_a & reset_n;
    assign grant_b = pick_b & reset_n;

    assign a_waitrequest = req_a & ~grant_a;
    assign b_waitrequest = req_b & ~grant_b;

    always_comb begin
        owner_d = owner_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        if (grant_a) begin
            if (owner_q == OWN_A) begin
                cnt_d = sat_inc(cnt_q);
            end else begin
                owner_d = OWN_A;
                cnt_d   = 8'd1;
                rr_d    = RR_B;
            end
        end else if (grant_b) begin
            if (owner_q == OWN_B) begin
                cnt_d = sat_inc(cnt_q);
            end else begin
                owner_d = OWN_B;
                cnt_d   = 8'd1;
                rr_d    = RR_A;
            end
        end else begin
            owner_d = OWN_NONE;
            cnt_d   = 8'd0;
        end
    end

    // Read+write together is executed as a write: no data return, error latched.
    always_comb begin
        a_rvalid_d = grant_a & a_read & ~a_write;
        b_rvalid_d = grant_b & b_read & ~b_write;
        err_d      = err_q
                   | (grant_a & a_read & a_write)
                   | (grant_b & b_read & b_write);
    end

    always_comb begin
        mem_chipselect = grant_a | grant_b;
        mem_address    = b_address;
        mem_writedata  = b_writedata;
        mem_byteenable = b_byteenable;
        mem_write      = grant_b & b_write;
        if (grant_a) begin
            mem_address    = a_address;
            mem_writedata  = a_writedata;
            mem_byteenable = a_byteenable;
            mem_write      = a_write;
        end
    end

    // NOTE: state registers use non-blocking (<=) so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q    <= OWN_NONE;
            cnt_q      <= 8'd0;
            rr_q       <= RR_A;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            err_q      <= err_d;
        end
    end

    assign a_readdatavalid = a_rvalid_q;
    assign b_readdatavalid = b_rvalid_q;
    assign a_readdata      = mem_readdata;
    assign b_readdata      = mem_readdata;
    assign mem_clken       = 1'b1;
    assign err_rw          = err_q;

endmodule
